// File: rtl/byte_serial_adder_ctrl_if.sv
// Host-side bus for the byte-serial adder sequencer.
//   master : host, drives start/sub/cin/a/b and observes the result
//   slave  : sequencer, receives the request and returns busy/done/sum/cout/overflow
interface byte_serial_adder_ctrl_if #(
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W = 8 * NBYTES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/byte_serial_adder_ctrl.sv
// Wide add/subtract sequencer that reuses one 8-bit adder slice across
// NBYTES byte lanes, LSB first, keeping the inter-byte carry in a register.
//   i_clk : system clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : slave side of byte_serial_adder_ctrl_if
//           in : start, sub, cin, a, b
//           out: busy, done, sum, cout, overflow (all registered)
module byte_serial_adder_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    byte_serial_adder_ctrl_if.slave        bus
);
    localparam int unsigned W        = 8 * NBYTES;
    localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_carry_nxt;
    logic [W-1:0]     w_a_nxt;
    logic [W-1:0]     w_b_nxt;
    logic [W-1:0]     w_sum_nxt;
    logic             w_cout_nxt;
    logic             w_ovf_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Shared 8-bit adder slice: {Cout, Sum} = A[idx] + Beff[idx] + carry
    logic [7:0] w_a_byte;
    logic [7:0] w_b_byte;
    logic [8:0] w_slice;

    assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
    assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];
    assign w_slice  = 9'(w_a_byte) + 9'(w_b_byte) + 9'(r_carry);

    // Next-state and next-register values
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_carry_nxt = r_carry;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    // Subtract is A + ~B + 1, so invert B here and force carry-in
                    w_a_nxt     = bus.a;
                    w_b_nxt     = bus.b ^ {W{bus.sub}};
                    w_carry_nxt = bus.sub | bus.cin;
                    w_idx_nxt   = '0;
                    w_sum_nxt   = '0;
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                w_sum_nxt[{r_idx, 3'b000} +: 8] = w_slice[7:0];
                w_carry_nxt                     = w_slice[8];
                if (r_idx == LAST_IDX) begin
                    // Top byte: signed overflow when operand signs agree but result sign differs
                    w_cout_nxt  = w_slice[8];
                    w_ovf_nxt   = (r_a[W-1] == r_b[W-1]) & (w_slice[7] != r_a[W-1]);
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Status flags are registered from the upcoming state
        w_busy_nxt = (w_state_nxt == S_ADD);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_carry <= w_carry_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Self-checking bench for byte_serial_adder_ctrl: directed corner cases plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_byte_serial_adder_ctrl;
    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;
    localparam int unsigned CLK_PERIOD = 10;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    byte_serial_adder_ctrl_if #(.NBYTES(NB)) bus ();

    byte_serial_adder_ctrl #(.NBYTES(NB)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: W-bit add/subtract with two's-complement overflow rule
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic c,
                                   output logic [W-1:0] sum, output logic co,
                                   output logic ovf);
        logic [W:0] full;
        if (s) full = {1'b0, a} - {1'b0, b} + (W+1)'(1) * 0 + ({1'b0, {W{1'b0}}} | (W+1)'(0));
        else   full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        sum = full[W-1:0];
        if (s) begin
            co  = (a >= b);
            ovf = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
        end else begin
            co  = full[W];
            ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation; called 1 time unit after a rising edge with DUT in IDLE.
    // noise: toggle start/operands randomly while busy and in DONE.
    // hold : leave start high afterwards for back-to-back acceptance.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c,
                         input bit noise, input bit hold, output time t_done);
        logic [W-1:0] e_sum;
        logic         e_co;
        logic         e_ovf;
        int           lat;
        int           busy_cnt;
        bit           seen;
        ref_op(a, b, s, c, e_sum, e_co, e_ovf);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        bus.cin   = c;
        step();
        check("accept_busy", 64'(bus.busy), 64'(1));
        check("accept_sum_clr", 64'(bus.sum), 64'(0));
        busy_cnt = 1;
        lat      = 0;
        seen     = 1'b0;
        t_done   = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (noise) begin
                bus.start = 1'($urandom);
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.sub   = 1'($urandom);
                bus.cin   = 1'($urandom);
            end else if (!hold) begin
                bus.start = 1'b0;
            end
            step();
            if (bus.done) begin
                lat    = cyc;
                seen   = 1'b1;
                t_done = $time;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        check("done_seen", 64'(seen), 64'(1));
        check("latency", 64'(lat), 64'(NB));
        check("busy_cycles", 64'(busy_cnt), 64'(NB));
        check("done_busy_low", 64'(bus.busy), 64'(0));
        check("sum", 64'(bus.sum), 64'(e_sum));
        check("cout", 64'(bus.cout), 64'(e_co));
        check("overflow", 64'(bus.overflow), 64'(e_ovf));
        // start during DONE must not be accepted
        bus.start = (noise || hold) ? 1'b1 : 1'b0;
        step();
        check("done_pulse_end", 64'(bus.done), 64'(0));
        check("idle_busy", 64'(bus.busy), 64'(0));
        check("sum_held", 64'(bus.sum), 64'(e_sum));
        if (!hold) bus.start = 1'b0;
    endtask

    initial begin
        time t_prev;
        time t_now;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        step();
        step();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_sum", 64'(bus.sum), 64'(0));
        check("rst_cout", 64'(bus.cout), 64'(0));
        check("rst_ovf", 64'(bus.overflow), 64'(0));
        rst = 1'b0;
        step();

        // Directed corners
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, t_now);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1'b0, t_now);
        do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b0, t_now);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, t_now);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, t_now);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 1'b1, 1'b0, t_now);

        // Reset in the third ADD cycle aborts the operation
        bus.start = 1'b1;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0BAD_F00D;
        bus.sub   = 1'b0;
        bus.cin   = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_sum", 64'(bus.sum), 64'(0));
        check("abort_cout", 64'(bus.cout), 64'(0));
        check("abort_ovf", 64'(bus.overflow), 64'(0));
        begin
            bit any_done = 1'b0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (bus.done || bus.busy) any_done = 1'b1;
            end
            check("abort_quiet", 64'(any_done), 64'(0));
        end
        do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, t_now);

        // Back-to-back with start held high: done pulses every NB+2 cycles
        do_op(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, t_prev);
        for (int k = 0; k < 5; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1, t_now);
            check("b2b_spacing", 64'((t_now - t_prev) / CLK_PERIOD), 64'(NB + 2));
            t_prev = t_now;
        end
        bus.start = 1'b0;
        step();

        // Randomized operations, some with start/operand noise while busy
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) ra = {1'b0, {(W-1){1'b1}}};
            if ($urandom_range(0, 5) == 0) rb = {1'b1, {(W-1){1'b0}}};
            do_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, t_now);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #(CLK_PERIOD * 50000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
